// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared constants for the UART TX, RX and receive-FIFO blocks.
//   DATA_W     : byte width carried by the UART
//   FIFO_DEPTH : default receive FIFO entry count (power of two)
//   CLK_VALUE  : system clock frequency in Hz
//   BAUD       : line rate in bits per second
package uart_pkg;

    localparam int DATA_W       = 8;
    localparam int FIFO_DEPTH   = 16;
    localparam int CLK_VALUE    = 100_000_000;
    localparam int BAUD         = 9600;
    localparam int CLKS_PER_BIT = CLK_VALUE / BAUD;

    // Width of an entry counter able to hold 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
//   Single-clock FIFO: storage, wrapping pointers and the entry count.
//   Decides acceptance of the incoming write and read requests.
//   Ports:
//     clk, rst_n : clock / async active-low reset
//     wr_req     : write request, wr_data is stored when accepted
//     rd_req     : read request
//     wr_acc     : write accepted this cycle (not full, or a read frees a slot)
//     rd_acc     : read accepted this cycle (not empty)
//     head       : entry at the read pointer (valid when not empty)
//     level      : current entry count, empty/full derived from it
module uart_sync_fifo #(
    parameter int DATA_W = uart_pkg::DATA_W,
    parameter int DEPTH  = uart_pkg::FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_req,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_req,
    output logic                     wr_acc,
    output logic                     rd_acc,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;

    assign empty  = (level == '0);
    assign full   = (level == LW'(DEPTH));
    assign rd_acc = rd_req & ~empty;
    // A read in the same cycle frees the slot, so a full FIFO still takes it.
    assign wr_acc = wr_req & (~full | rd_acc);
    assign head   = mem[rptr];

    // Storage is not reset; only pointers/level define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr] <= wr_data;
    end

    // DEPTH is a power of two, so plain increment wraps DEPTH-1 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + 1'b1;
            if (rd_acc) rptr <= rptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Buffers bytes from a UART receiver. One write per rising edge of
//   rx_flag, registered read data with a one-cycle valid pulse, and a
//   sticky overflow flag for bytes dropped while full.
//   Ports:
//     clk, rst_n       : clock / async active-low reset
//     rx_data, rx_flag : received byte and frame-complete level
//     rd_en            : consumer read request
//     rd_data,rd_valid : byte for an accepted read, valid pulse one cycle later
//     empty, full      : FIFO holds 0 / DEPTH entries
//     level            : entry count
//     overflow,clr_ovf : sticky drop flag and its synchronous clear
module uart_rx_fifo #(
    parameter int DATA_W = uart_pkg::DATA_W,
    parameter int DEPTH  = uart_pkg::FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_flag,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    logic              rx_flag_q;
    logic              wr_req;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] head;

    assign wr_req = rx_flag & ~rx_flag_q;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_req  (wr_req),
        .wr_data (rx_data),
        .rd_req  (rd_en),
        .wr_acc  (wr_acc),
        .rd_acc  (rd_acc),
        .head    (head),
        .level   (level),
        .empty   (empty),
        .full    (full)
    );

    // rx_flag_q resets high so a flag already high at reset release is
    // not mistaken for a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_flag_q <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            overflow  <= 1'b0;
        end else begin
            rx_flag_q <= rx_flag;
            rd_valid  <= rd_acc;
            if (rd_acc) rd_data <= head;
            // A drop in the same cycle as a clear leaves the flag set.
            if (wr_req & ~wr_acc) overflow <= 1'b1;
            else if (clr_ovf)     overflow <= 1'b0;
        end
    end

endmodule
